seq_gen: RTL and testbench

Serial pattern transmitter: on a start request it latches a parallel pattern, bit length and repeat count, then emits the pattern MSB-first on a one-bit serial line, one bit per clock, repeating it the requested number of times. It is the stimulus source for the team's serial sequence-detector blocks, driving their `din` input. It also serves as a standalone bit-pattern generator in lab builds.

---
 rtl/seq_gen.sv | 129 ++++++++++++
 tb/tb_seq_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a pattern, length and repeat count on start, then
// shifts the pattern out MSB-first, one bit per clock, for the requested number of passes.
module seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;

  logic dout_q, dout_d;
  logic dvalid_q, dvalid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [LEN_W-1:0] len_clamped;
  logic [WIDTH-1:0] pat_shifted;

  // Lengths above WIDTH would index past the pattern register.
  assign len_clamped = (32'(len) > WIDTH) ? LEN_W'(WIDTH) : len;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pat_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      rep_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          pat_d = pattern;
          len_d = len_clamped;
          rep_d = reps;
          if (len_clamped == '0 || reps == '0) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d   = len_clamped - LEN_W'(1);
            state_d = StSend;
          end
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
        end else if (idx_q == '0) begin
          if (rep_q > REP_W'(1)) begin
            // Wrap straight into the next pass with no idle gap.
            idx_d = len_q - LEN_W'(1);
            rep_d = rep_q - REP_W'(1);
          end else begin
            state_d = StDone;
          end
        end else begin
          idx_d = idx_q - LEN_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from next state so they leave the block straight from flops.
  always_comb begin
    pat_shifted = pat_d >> idx_d;
    dvalid_d    = (state_d == StSend);
    dout_d      = dvalid_d & pat_shifted[0];
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a table of directed requests, randomized requests against a bit-queue
// reference model, plus reset and async-reset-mid-transfer sequences.
module tb_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       dout;
  logic       dvalid;
  logic       busy;
  logic       done;

  int passed;
  int total;
  bit exp_q[$];

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] reps;
    int         abort_at;
    bit         noise;
    string      exp;
  } vec_t;

  vec_t tbl[9];

  seq_gen #(
    .WIDTH(8),
    .LEN_W(4),
    .REP_W(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .pattern(pattern),
    .len    (len),
    .reps   (reps),
    .dout   (dout),
    .dvalid (dvalid),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %b, required %b", name, act, expv);
  endtask

  task automatic check_outs(input string tag, input logic e_dout, input logic e_dvalid,
                            input logic e_busy, input logic e_done);
    check({tag, " dout"}, dout, e_dout);
    check({tag, " dvalid"}, dvalid, e_dvalid);
    check({tag, " busy"}, busy, e_busy);
    check({tag, " done"}, done, e_done);
  endtask

  // Reference: the stream is simply the low clamped_len bits, MSB first, repeated reps times.
  task automatic build_model(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp);
    int cl;
    exp_q.delete();
    cl = (int'(ln) > 8) ? 8 : int'(ln);
    for (int r = 0; r < int'(rp); r++)
      for (int i = cl - 1; i >= 0; i--) exp_q.push_back(pat[i]);
  endtask

  task automatic load_string(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i) == 8'h31);
  endtask

  // Issue one request and check every cycle against exp_q. abort_at: cycle (1-based) whose
  // closing edge samples abort, 0 for none. noise: scramble inputs and pulse start while busy.
  task automatic run_xfer(input string tag, input logic [7:0] pat, input logic [3:0] ln,
                          input logic [3:0] rp, input int abort_at, input bit noise);
    int    n;
    int    last;
    bit    aborted;
    string cname;
    n       = exp_q.size();
    aborted = (abort_at > 0) && (abort_at <= n);
    last    = aborted ? abort_at + 1 : n + 2;
    @(negedge clk);
    pattern = pat;
    len     = ln;
    reps    = rp;
    abort   = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      cname = $sformatf("%s c%0d", tag, c);
      if (aborted && c == abort_at + 1) check_outs(cname, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (c <= n) check_outs(cname, exp_q[c-1], 1'b1, 1'b1, 1'b0);
      else if (c == n + 1) check_outs(cname, 1'b0, 1'b0, 1'b1, 1'b1);
      else check_outs(cname, 1'b0, 1'b0, 1'b0, 1'b0);
      if (c < last) begin
        abort = (c == abort_at);
        if (noise) begin
          start   = (c == 1) | 1'($urandom_range(0, 1));
          pattern = 8'($urandom);
          len     = 4'($urandom);
          reps    = 4'($urandom);
        end
      end else begin
        abort = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] rpat;
    logic [3:0] rlen;
    logic [3:0] rrep;
    int         ab;
    passed  = 0;
    total   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;

    tbl[0] = '{8'h0B, 4'd4, 4'd2, 0, 1'b0, "10111011"};
    tbl[1] = '{8'hA5, 4'd8, 4'd1, 0, 1'b0, "10100101"};
    tbl[2] = '{8'h5A, 4'd0, 4'd3, 0, 1'b0, ""};
    tbl[3] = '{8'h1F, 4'd5, 4'd0, 0, 1'b0, ""};
    tbl[4] = '{8'hFF, 4'd12, 4'd1, 0, 1'b0, "11111111"};
    tbl[5] = '{8'hC3, 4'd8, 4'd1, 3, 1'b1, "11000011"};
    tbl[6] = '{8'h06, 4'd3, 4'd3, 0, 1'b1, "110110110"};
    tbl[7] = '{8'h01, 4'd1, 4'd15, 0, 1'b0, "111111111111111"};
    tbl[8] = '{8'h0B, 4'd2, 4'd1, 3, 1'b0, "11"};

    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("post-reset idle", 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      load_string(tbl[i].exp);
      run_xfer($sformatf("tbl%0d", i), tbl[i].pat, tbl[i].len, tbl[i].reps, tbl[i].abort_at,
               tbl[i].noise);
    end

    // Async reset while streaming, then a clean transfer afterwards.
    @(negedge clk);
    pattern = 8'hA5;
    len     = 4'd8;
    reps    = 4'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("arst pre dvalid", dvalid, 1'b1);
    check("arst pre busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_outs("arst during", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    build_model(8'h96, 4'd8, 4'd1);
    run_xfer("arst after", 8'h96, 4'd8, 4'd1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rpat = 8'($urandom);
      rlen = 4'($urandom_range(0, 15));
      rrep = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
      build_model(rpat, rlen, rrep);
      ab = 0;
      if (exp_q.size() > 0 && $urandom_range(0, 3) == 0)
        ab = $urandom_range(1, exp_q.size() + 1);
      run_xfer($sformatf("rnd%0d", t), rpat, rlen, rrep, ab, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
